// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder
// Pipelined carry-lookahead adder/subtractor. The operands are split into STAGES
// chunks of CW = WIDTH/STAGES bits. Chunk k is added by a CW-bit CLA in front of
// stage register k. The carry out of that chunk is registered and feeds the next
// stage. Operand chunks that are still pending travel alongside the partial sum.
// Stage register STAGES-1 drives the outputs directly.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high; clears valids and the result outputs
//   flush      synchronous; clears every in-flight valid bit, drops the offered beat
//   in_valid   operand beat valid          in_ready   beat can be accepted this cycle
//   a, b       operands (WIDTH)            cin        carry-in (ignored when sub=1)
//   sub        1: sum = a - b
//   out_valid  result valid                out_ready  downstream accepts result
//   sum        result (WIDTH)              cout       carry out of the MSB (sub: 1 = no borrow)
//   ovf        signed overflow of the effective operands
module pipe_cla_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_cla_adder: WIDTH must be a positive multiple of STAGES");
   end

   // CW-bit carry-lookahead add. Every carry is formed directly from the
   // generate/propagate terms below it rather than from the previous carry.
   // Returns {carry_out, sum}.
   function automatic logic [CW:0] cla_add(input logic [CW-1:0] x,
                                           input logic [CW-1:0] y,
                                           input logic          ci);
      logic [CW-1:0] g;
      logic [CW-1:0] p;
      logic [CW:0]   c;
      logic          term;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = ci;
      for (int i = 1; i <= CW; i++) begin
         term = ci;
         for (int j = 0; j < i; j++) term = term & p[j];
         c[i] = term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int m = j + 1; m < i; m++) term = term & p[m];
            c[i] = c[i] | term;
         end
      end
      return {c[CW], p ^ c[CW-1:0]};
   endfunction

   logic              stall;
   logic              adv;
   logic [WIDTH-1:0]  b_eff;
   logic [STAGES-1:0] vld_p;

   assign stall     = out_valid & ~out_ready;
   assign adv       = ~stall;
   assign in_ready  = ~stall;
   assign out_valid = vld_p[STAGES-1];

   // Subtraction is a + ~b + 1; the inversion happens before the first register.
   assign b_eff = sub ? ~b : b;

   // Valid bits shift as one unit. Bubbles are never compressed.
   // Flush wins over both stall and accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p <= '0;
      end else if (flush) begin
         vld_p <= '0;
      end else if (adv) begin
         vld_p[0] <= in_valid;
         for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int HI = WIDTH - k * CW;   // operand bits not yet added

      logic [HI-1:0]       x_s;
      logic [HI-1:0]       y_s;
      logic                c_s;
      logic [CW:0]         r_s;
      logic [(k+1)*CW-1:0] sum_s;

      // ---- stage k input: raw operands or stage k-1 register ----
      if (k == 0) begin : g_src
         assign x_s   = a;
         assign y_s   = b_eff;
         assign c_s   = sub | cin;
         assign sum_s = r_s[CW-1:0];
      end else begin : g_src
         assign x_s   = g_stg[k-1].g_pend.a_p;
         assign y_s   = g_stg[k-1].g_pend.b_p;
         assign c_s   = g_stg[k-1].g_pend.cy_p;
         assign sum_s = {r_s[CW-1:0], g_stg[k-1].g_pend.sum_p};
      end

      assign r_s = cla_add(x_s[CW-1:0], y_s[CW-1:0], c_s);

      // ---- stage k register ----
      if (k < STAGES - 1) begin : g_pend
         logic [HI-CW-1:0]    a_p;
         logic [HI-CW-1:0]    b_p;
         logic                cy_p;
         logic [(k+1)*CW-1:0] sum_p;

         always_ff @(posedge clk) begin
            if (adv) begin
               a_p   <= x_s[HI-1:CW];
               b_p   <= y_s[HI-1:CW];
               cy_p  <= r_s[CW];
               sum_p <= sum_s;
            end
         end
      end else begin : g_last
         logic             ovf_d;
         logic [WIDTH-1:0] sum_p;
         logic             cout_p;
         logic             ovf_p;

         // The top chunk holds the operand sign bits, so overflow is decided here.
         assign ovf_d = (x_s[HI-1] == y_s[HI-1]) & (r_s[CW-1] != x_s[HI-1]);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sum_p  <= '0;
               cout_p <= 1'b0;
               ovf_p  <= 1'b0;
            end else if (adv) begin
               sum_p  <= sum_s;
               cout_p <= r_s[CW];
               ovf_p  <= ovf_d;
            end
         end

         assign sum  = sum_p;
         assign cout = cout_p;
         assign ovf  = ovf_p;
      end
   end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb_pipe_cla_adder
// Directed bench for pipe_cla_adder at WIDTH=32, STAGES=2 (two-edge latency).
// Inputs are driven after the falling edge and outputs are sampled there too.
module tb_pipe_cla_adder;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;

   int n_chk;
   int n_err;

   pipe_cla_adder #(.WIDTH(32), .STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from plain wide addition.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic s);
      logic [31:0] ye;
      logic [32:0] t;
      logic        o;
      ye = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, ye} + {32'd0, (s | ci)};
      o  = (x[31] == ye[31]) && (t[31] != x[31]);
      return {o, t};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = ci;
      sub = s;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] es, input logic ec, input logic eo);
      chk({tag, "_vld"}, out_valid, 1);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"}, ovf, eo);
   endtask

   // One isolated beat: checks the latency and the result.
   task automatic run1(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic s,
                       input logic [31:0] es, input logic ec, input logic eo);
      drive(x, y, ci, s);
      tick();
      in_valid = 1'b0;
      chk({tag, "_lat"}, out_valid, 0);
      tick();
      expect_out(tag, es, ec, eo);
      tick();
      chk({tag, "_drain"}, out_valid, 0);
   endtask

   logic [31:0] va [8];
   logic [31:0] vb [8];
   logic [33:0] ve;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      sub = 1'b0;
      out_ready = 1'b1;

      #1;
      chk("rst_vld", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_rdy", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_vld", out_valid, 0);

      // Basic add, chunk-crossing carry, subtraction and overflow cases
      run1("t1", 32'd5, 32'd3, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0);
      run1("t2", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run1("t3_sub", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      run1("t3_cin", 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A, 1'b0, 1'b0);
      run1("sub_cin_ign", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
      run1("sub_borrow", 32'd3, 32'd10, 1'b0, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0);
      run1("pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run1("neg_ovf", 32'hC000_0000, 32'h9000_0000, 1'b0, 1'b0, 32'h5000_0000, 1'b1, 1'b1);

      // Back-to-back stream of 8 beats
      for (int i = 0; i < 8; i++) begin
         va[i] = 32'h0101_0101 * i + 32'h0000_FFF0;
         vb[i] = 32'h0000_0011 + 32'h0100_0000 * i;
      end
      for (int i = 0; i < 9; i++) begin
         if (i < 8) drive(va[i], vb[i], 1'b0, 1'b0);
         else in_valid = 1'b0;
         tick();
         if (i == 0) begin
            chk("t4_lat", out_valid, 0);
         end else begin
            ve = model(va[i-1], vb[i-1], 1'b0, 1'b0);
            chk($sformatf("t4_vld%0d", i - 1), out_valid, 1);
            chk($sformatf("t4_sum%0d", i - 1), sum, ve[31:0]);
            chk($sformatf("t4_cout%0d", i - 1), cout, ve[32]);
         end
      end
      tick();
      chk("t4_drain", out_valid, 0);

      // Backpressure: hold the output for 3 cycles while a beat waits at the input
      drive(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      tick();
      drive(32'hAAAA_AAAA, 32'h5555_5556, 1'b0, 1'b0);
      tick();
      expect_out("st_b0", 32'h3333_3333, 1'b0, 1'b0);
      out_ready = 1'b0;
      drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("st_rdy%0d", i), in_ready, 0);
         chk($sformatf("st_vld%0d", i), out_valid, 1);
         chk($sformatf("st_hold%0d", i), sum, 32'h3333_3333);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("st_rel_rdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      expect_out("st_b1", 32'h0000_0000, 1'b1, 1'b0);
      tick();
      expect_out("st_b2", 32'h8000_0000, 1'b0, 1'b1);
      tick();
      chk("st_drain", out_valid, 0);

      // Flush with one beat in flight and one offered in the flush cycle
      drive(32'd100, 32'd1, 1'b0, 1'b0);
      tick();
      drive(32'd200, 32'd2, 1'b0, 1'b0);
      flush = 1'b1;
      #1;
      chk("fl_rdy", in_ready, 1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_vld0", out_valid, 0);
      tick();
      chk("fl_vld1", out_valid, 0);

      // Flush with two beats held in the stalled pipeline
      out_ready = 1'b0;
      drive(32'd100, 32'd1, 1'b0, 1'b0);
      tick();
      drive(32'd200, 32'd2, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("fl2_pre_vld", out_valid, 1);
      flush = 1'b1;
      #1;
      chk("fl2_rdy", in_ready, 0);
      tick();
      flush = 1'b0;
      chk("fl2_vld0", out_valid, 0);
      out_ready = 1'b1;
      tick();
      chk("fl2_vld1", out_valid, 0);
      tick();
      chk("fl2_vld2", out_valid, 0);
      run1("t5_2p2", 32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0);

      // Random operands against the reference model
      for (int i = 0; i < 8; i++) begin
         logic [31:0] rx;
         logic [31:0] ry;
         logic        rc;
         logic        rs;
         rx = $urandom;
         ry = $urandom;
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         ve = model(rx, ry, rc, rs);
         run1($sformatf("rnd%0d", i), rx, ry, rc, rs, ve[31:0], ve[32], ve[33]);
      end

      // Asynchronous reset while a result is held on the output
      drive(32'hC000_0000, 32'h9000_0000, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
      expect_out("t6_pre", 32'h5000_0000, 1'b1, 1'b1);
      out_ready = 1'b0;
      #1;
      chk("t6_pre_rdy", in_ready, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_vld", out_valid, 0);
      chk("t6_sum", sum, 0);
      chk("t6_cout", cout, 0);
      chk("t6_ovf", ovf, 0);
      chk("t6_rdy", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("t6_post_vld", out_valid, 0);
      run1("t6_t1", 32'd5, 32'd3, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
